rtc_data_sender: RTL
====================

Name: rtc_data_sender

Overview:
Producer end of the `datoRTC` byte stream consumed by the display interface.
- On each pre-refresh tick it reads the RTC register set one item at a time through a one-cycle-latency register port.
- Each byte read is presented on `dato_rtc` with a valid/ready handshake, in the fixed order the display interface stores them.
- Sends 9 clock items, or 13 when the timer is active (clock plus 4 timer items).

Parameters:
- `CLK_BASE`, 8'h20, RTC address of clock item 0 (centesimas); clock items occupy `CLK_BASE`..`CLK_BASE+8`.
- `TMR_BASE`, 8'h40, RTC address of timer item 0 (centesimasT); timer items occupy `TMR_BASE`..`TMR_BASE+3`.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `tick`  in  1  one-cycle start pulse, issued before screen refresh
- `temporizador`  in  1  timer active; sampled only when a tick is accepted
- `rd_en`  out  1  RTC register read strobe, one cycle
- `rd_addr`  out  8  RTC register address
- `rd_data`  in  8  RTC read data, valid the cycle after `rd_en`
- `dato_rtc`  out  8  byte to the display interface
- `dato_idx`  out  4  item index of `dato_rtc`, 0..12
- `dato_valid`  out  1  `dato_rtc`/`dato_idx` valid
- `dato_ready`  in  1  consumer accepts the byte
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse after the last item transfers
- `overrun`  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Reset: every output is 0, state IDLE, index 0, latched count 9. A reset asserted in any state aborts the sequence the same cycle; no `done` pulse is issued.
- Item order, by index:
  - 0..8: centesimas, segundos, minutos, horas, fecha, mes, año, diaSemana, numeroSemana → `rd_addr = CLK_BASE + idx`.
  - 9..12: centesimasT, segundosT, minutosT, horasT → `rd_addr = TMR_BASE + (idx-9)`.
- Count latch: last index = 12 if `temporizador` = 1 at the accepted tick, else 8. Later changes to `temporizador` have no effect on the running sequence.
- States: IDLE, READ, CAPT, SEND, DONE.
  - IDLE: `tick` = 1 → latch count, idx := 0, go to READ.
  - READ: `rd_en` = 1, `rd_addr` driven for idx. Next state CAPT.
  - CAPT: register `rd_data` into `dato_rtc` and set `dato_valid` = 1 for the next cycle. Next state SEND.
  - SEND: hold `dato_valid`, `dato_rtc` and `dato_idx` stable while `dato_ready` = 0. Transfer happens on a cycle where `dato_valid` & `dato_ready` are both 1; `dato_valid` drops the next cycle.
    - After a transfer: if idx = last, go to DONE; else idx := idx+1 and go to READ.
  - DONE: `done` = 1 for one cycle, then IDLE.
- `rd_en` is 0 in every state except READ. `rd_addr` is 0 in IDLE.
- `busy` = 1 in READ, CAPT, SEND and DONE.
- Timing with tick sampled at cycle t and `dato_ready` held at 1:
  - `rd_en` at t+1; `dato_valid` first at t+3.
  - 3 cycles per item.
  - Last transfer at t+27 (9 items) or t+39 (13 items).
  - `done` at t+28 or t+40; back in IDLE the following cycle, where a new tick is accepted.
- A tick while `busy` = 1, including the DONE cycle, is ignored: `overrun` pulses for 1 cycle and the sequence continues unchanged.
- Data passes through unmodified; no BCD checking.
- `dato_idx` wraps to 0 only through a new start; it never exceeds the latched last index.

Test Plan:
- Reset, then tick with `temporizador` = 0, `dato_ready` = 1, RTC model returning `addr ^ 8'hA5` → 9 transfers, idx 0..8, addresses 0x20..0x28, data 0x85..0x8D, `done` at t+28, `busy` low at t+29.
- Tick with `temporizador` = 1 → 13 transfers; idx 9..12 read addresses 0x40..0x43 with data 0xE5..0xE6 pattern (`addr ^ 8'hA5`); `done` at t+40.
- Hold `dato_ready` = 0 for 5 cycles on idx 3 → `dato_valid`, `dato_rtc` and `dato_idx` stay stable and no `rd_en` occurs until ready rises; total sequence stretched by exactly 5 cycles.
- Second tick at t+10 → `overrun` one-cycle pulse at t+10, sequence order and timing unchanged, single `done`.
- Assert `reset` during SEND of idx 5 → next cycle all outputs 0, no `done`; a following tick restarts at idx 0.
- Toggle `temporizador` 0→1 mid-run → still exactly 9 items transferred.

Source files
------------

// File: rtl/rtc_data_sender.sv
// Reads the RTC clock/timer registers on each pre-refresh tick and
// streams them to the display interface over a valid/ready byte port.
module rtc_data_sender #(
  parameter logic [7:0] CLK_BASE = 8'h20,
  parameter logic [7:0] TMR_BASE = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       temporizador,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] dato_rtc,
  output logic [3:0] dato_idx,
  output logic       dato_valid,
  input  logic       dato_ready,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    DONE
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [3:0] idx;
  logic [3:0] idx_d;
  logic [3:0] last;
  logic [3:0] last_d;
  logic [7:0] data_q;
  logic [7:0] data_d;
  logic       valid_q;
  logic       valid_d;
  logic [7:0] item_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 4'd0;
      last    <= 4'd8;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      last    <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    last_d  = last;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state)
      IDLE: begin
        if (tick) begin
          last_d  = temporizador ? 4'd12 : 4'd8;
          idx_d   = 4'd0;
          state_d = READ;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        data_d  = rd_data;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && dato_ready) begin
          valid_d = 1'b0;
          if (idx == last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx + 4'd1;
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clock items sit at CLK_BASE+idx, timer items restart at TMR_BASE.
  always_comb begin
    if (idx <= 4'd8) begin
      item_addr = CLK_BASE + {4'd0, idx};
    end else begin
      item_addr = TMR_BASE + {4'd0, idx} - 8'd9;
    end
  end

  assign rd_en      = (state == READ);
  assign rd_addr    = (state == READ) ? item_addr : 8'd0;
  assign dato_rtc   = data_q;
  assign dato_idx   = idx;
  assign dato_valid = valid_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign overrun    = tick && busy;

endmodule
